// File: rtl/helios_single_fpga.sv
// Union-find decoder over a 3D lattice of stabilizer PUs: grow odd clusters, merge, report roots.
// Optional macro HELIOS_CYCLE_COUNTER_EN builds the per-round cycle counter; otherwise cycle_counter reads 0.
module helios_single_fpga #(
    parameter int CODE_DISTANCE_X = 5,
    parameter int CODE_DISTANCE_Z = 4,
    parameter int WEIGHT_X = 2,
    parameter int WEIGHT_Z = 2,
    parameter int WEIGHT_M = 2,
    localparam int MEASUREMENT_ROUNDS = (CODE_DISTANCE_X > CODE_DISTANCE_Z) ? CODE_DISTANCE_X : CODE_DISTANCE_Z,
    localparam int PU_COUNT = CODE_DISTANCE_X * CODE_DISTANCE_Z * MEASUREMENT_ROUNDS,
    localparam int PER_DIM_WIDTH = $clog2(MEASUREMENT_ROUNDS),
    localparam int ADDRESS_WIDTH = 3 * PER_DIM_WIDTH,
    localparam int ITERATION_COUNTER_WIDTH = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                new_round_start,
    input  logic [PU_COUNT-1:0]                 measurements,
    output logic [ADDRESS_WIDTH*PU_COUNT-1:0]   roots,
    output logic                                result_valid,
    output logic [ITERATION_COUNTER_WIDTH-1:0]  iteration_counter,
    output logic [31:0]                         cycle_counter,
    output logic [2:0]                          global_stage
);
    localparam int DX = CODE_DISTANCE_X;
    localparam int DZ = CODE_DISTANCE_Z;
    localparam int NR = MEASUREMENT_ROUNDS;
    localparam int PW = PER_DIM_WIDTH;
    localparam int AW = ADDRESS_WIDTH;
    localparam int WMAX = (WEIGHT_X > WEIGHT_Z) ? ((WEIGHT_X > WEIGHT_M) ? WEIGHT_X : WEIGHT_M)
                                                : ((WEIGHT_Z > WEIGHT_M) ? WEIGHT_Z : WEIGHT_M);
    localparam int EW = $clog2(WMAX + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOADING = 3'd1,
        S_GROW    = 3'd2,
        S_MERGE   = 3'd3,
        S_RESULT  = 3'd4
    } stage_t;

    stage_t stage_q, stage_d;
    logic [PU_COUNT-1:0] defect_q;
    logic [ITERATION_COUNTER_WIDTH-1:0] iter_q;
    // Edge counters indexed by the lower-address endpoint; entries with no edge stay zero.
    logic [EW-1:0] ex_q [PU_COUNT];
    logic [EW-1:0] ez_q [PU_COUNT];
    logic [EW-1:0] em_q [PU_COUNT];
    logic [EW-1:0] bl_q [PU_COUNT];
    logic [EW-1:0] bh_q [PU_COUNT];
    logic [AW-1:0] root_q [PU_COUNT];
    logic [AW-1:0] root_d [PU_COUNT];
    logic [AW-1:0] own_addr [PU_COUNT];
    logic [PU_COUNT-1:0] bnd_full, odd_root, in_odd;
    logic any_odd, root_changed, par_acc, touch_acc;

    function automatic logic [EW-1:0] sat_add(input logic [EW-1:0] cnt, input logic [1:0] inc,
                                              input int weight);
        logic [EW:0] sum;
        sum = {1'b0, cnt} + {{(EW-1){1'b0}}, inc};
        if (sum >= (EW+1)'(weight)) return EW'(weight);
        return sum[EW-1:0];
    endfunction

    for (genvar gk = 0; gk < NR; gk++) begin : g_k
        for (genvar gi = 0; gi < DX; gi++) begin : g_i
            for (genvar gj = 0; gj < DZ; gj++) begin : g_j
                localparam int N = gk*DX*DZ + gi*DZ + gj;
                assign own_addr[N] = {PW'(gk), PW'(gi), PW'(gj)};
                assign roots[AW*N +: AW] = root_q[N];
            end
        end
    end

    always_comb begin
        for (int q = 0; q < PU_COUNT; q++)
            bnd_full[q] = (bl_q[q] == EW'(WEIGHT_Z)) | (bh_q[q] == EW'(WEIGHT_Z));
    end

    // A cluster is named by its root address, so per-address parity/boundary identifies odd clusters.
    always_comb begin
        par_acc   = 1'b0;
        touch_acc = 1'b0;
        odd_root  = '0;
        in_odd    = '0;
        for (int r = 0; r < PU_COUNT; r++) begin
            par_acc   = 1'b0;
            touch_acc = 1'b0;
            for (int q = 0; q < PU_COUNT; q++) begin
                if (root_q[q] == own_addr[r]) begin
                    par_acc   = par_acc ^ defect_q[q];
                    touch_acc = touch_acc | bnd_full[q];
                end
            end
            odd_root[r] = par_acc & ~touch_acc;
        end
        for (int p = 0; p < PU_COUNT; p++)
            for (int r = 0; r < PU_COUNT; r++)
                if (root_q[p] == own_addr[r] && odd_root[r]) in_odd[p] = 1'b1;
        any_odd = |odd_root;
    end

    always_comb begin
        for (int n = 0; n < PU_COUNT; n++) root_d[n] = root_q[n];
        for (int k = 0; k < NR; k++) begin
            for (int i = 0; i < DX; i++) begin
                for (int j = 0; j < DZ; j++) begin
                    int n;
                    n = k*DX*DZ + i*DZ + j;
                    if (i < DX-1 && ex_q[n] == EW'(WEIGHT_X)) begin
                        if (root_q[n+DZ] < root_d[n]) root_d[n] = root_q[n+DZ];
                        if (root_q[n] < root_d[n+DZ]) root_d[n+DZ] = root_q[n];
                    end
                    if (j < DZ-1 && ez_q[n] == EW'(WEIGHT_Z)) begin
                        if (root_q[n+1] < root_d[n]) root_d[n] = root_q[n+1];
                        if (root_q[n] < root_d[n+1]) root_d[n+1] = root_q[n];
                    end
                    if (k < NR-1 && em_q[n] == EW'(WEIGHT_M)) begin
                        if (root_q[n+DX*DZ] < root_d[n]) root_d[n] = root_q[n+DX*DZ];
                        if (root_q[n] < root_d[n+DX*DZ]) root_d[n+DX*DZ] = root_q[n];
                    end
                end
            end
        end
        root_changed = 1'b0;
        for (int n = 0; n < PU_COUNT; n++)
            if (root_d[n] != root_q[n]) root_changed = 1'b1;
    end

    always_comb begin
        stage_d = stage_q;
        case (stage_q)
            S_LOADING: stage_d = any_odd ? S_GROW : S_RESULT;
            S_GROW:    stage_d = S_MERGE;
            S_MERGE:   if (!root_changed) stage_d = any_odd ? S_GROW : S_RESULT;
            default:   stage_d = stage_q;
        endcase
        if (new_round_start) stage_d = S_LOADING;
    end

    always_ff @(posedge clk) begin
        if (reset || new_round_start) begin
            stage_q  <= reset ? S_IDLE : stage_d;
            defect_q <= reset ? '0 : measurements;
            iter_q   <= '0;
            for (int n = 0; n < PU_COUNT; n++) begin
                ex_q[n]   <= '0;
                ez_q[n]   <= '0;
                em_q[n]   <= '0;
                bl_q[n]   <= '0;
                bh_q[n]   <= '0;
                root_q[n] <= own_addr[n];
            end
        end else begin
            stage_q <= stage_d;
            if (stage_q == S_GROW) begin
                for (int k = 0; k < NR; k++) begin
                    for (int i = 0; i < DX; i++) begin
                        for (int j = 0; j < DZ; j++) begin
                            int n;
                            n = k*DX*DZ + i*DZ + j;
                            if (i < DX-1)
                                ex_q[n] <= sat_add(ex_q[n], {1'b0, in_odd[n]} + {1'b0, in_odd[n+DZ]}, WEIGHT_X);
                            if (j < DZ-1)
                                ez_q[n] <= sat_add(ez_q[n], {1'b0, in_odd[n]} + {1'b0, in_odd[n+1]}, WEIGHT_Z);
                            if (k < NR-1)
                                em_q[n] <= sat_add(em_q[n], {1'b0, in_odd[n]} + {1'b0, in_odd[n+DX*DZ]}, WEIGHT_M);
                            if (j == 0)
                                bl_q[n] <= sat_add(bl_q[n], {1'b0, in_odd[n]}, WEIGHT_Z);
                            if (j == DZ-1)
                                bh_q[n] <= sat_add(bh_q[n], {1'b0, in_odd[n]}, WEIGHT_Z);
                        end
                    end
                end
                if (iter_q != '1) iter_q <= iter_q + 1'b1;
            end else if (stage_q == S_MERGE && root_changed) begin
                for (int n = 0; n < PU_COUNT; n++) root_q[n] <= root_d[n];
            end
        end
    end

`ifdef HELIOS_CYCLE_COUNTER_EN
    logic [31:0] cyc_q;
    always_ff @(posedge clk) begin
        if (reset || new_round_start) cyc_q <= '0;
        else if (stage_q == S_LOADING || stage_q == S_GROW || stage_q == S_MERGE) cyc_q <= cyc_q + 32'd1;
    end
    assign cycle_counter = cyc_q;
`else
    assign cycle_counter = '0;
`endif

    assign result_valid      = (stage_q == S_RESULT);
    assign iteration_counter = iter_q;
    assign global_stage      = stage_q;
endmodule

// File: tb/tb_helios_single_fpga.sv
// Randomized bench for helios_single_fpga; expected roots/iterations come from a union-find model.
module tb_helios_single_fpga;
    localparam int DX = 5;
    localparam int DZ = 4;
    localparam int NR = 5;
    localparam int N = DX*DZ*NR;
    localparam int AW = 9;
    localparam int RW = AW*N;
    localparam int EXP_W = RW + 8;

    logic clk = 1'b0;
    logic reset, new_round_start;
    logic [N-1:0] measurements;
    logic [RW-1:0] roots;
    logic result_valid;
    logic [7:0] iteration_counter;
    logic [31:0] cycle_counter;
    logic [2:0] global_stage;

    helios_single_fpga dut (
        .clk(clk), .reset(reset), .new_round_start(new_round_start), .measurements(measurements),
        .roots(roots), .result_valid(result_valid), .iteration_counter(iteration_counter),
        .cycle_counter(cycle_counter), .global_stage(global_stage)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int rises = 0;
    int pushes = 0;
    logic [EXP_W-1:0] exp_q[$];
    int e_a[$], e_b[$], e_w[$];
    int m_par[N];
    logic prev_valid = 1'b0;
    logic [EXP_W-1:0] mon_e;

    function automatic int pu_idx(int i, int j, int k);
        return i*DZ + j + k*DZ*DX;
    endfunction

    function automatic int pu_addr(int n);
        return (n / (DX*DZ)) * 64 + ((n % (DX*DZ)) / DZ) * 8 + (n % DZ);
    endfunction

    function automatic logic [RW-1:0] own_roots();
        logic [RW-1:0] r;
        for (int n = 0; n < N; n++) r[AW*n +: AW] = AW'(pu_addr(n));
        return r;
    endfunction

    function automatic int find_root(int x);
        while (m_par[x] != x) x = m_par[x];
        return x;
    endfunction

    // Reference: rebuild clusters from full edges each iteration, grow every edge touching odd clusters.
    function automatic logic [EXP_W-1:0] ref_decode(input logic [N-1:0] m);
        int cnt[$];
        bit c_par[N];
        bit c_touch[N];
        bit odd_pu[N];
        int iter, ra, rb, inc;
        bit any;
        logic [EXP_W-1:0] r;
        cnt = {};
        foreach (e_a[e]) cnt.push_back(0);
        iter = 0;
        for (int guard = 0; guard < 300; guard++) begin
            for (int n = 0; n < N; n++) begin
                m_par[n] = n; c_par[n] = 0; c_touch[n] = 0;
            end
            foreach (e_a[e]) begin
                if (e_b[e] >= 0 && cnt[e] == e_w[e]) begin
                    ra = find_root(e_a[e]);
                    rb = find_root(e_b[e]);
                    if (ra != rb) begin
                        if (pu_addr(ra) < pu_addr(rb)) m_par[rb] = ra;
                        else m_par[ra] = rb;
                    end
                end
            end
            for (int n = 0; n < N; n++) c_par[find_root(n)] ^= m[n];
            foreach (e_a[e])
                if (e_b[e] < 0 && cnt[e] == e_w[e]) c_touch[find_root(e_a[e])] = 1;
            any = 0;
            for (int n = 0; n < N; n++) begin
                odd_pu[n] = c_par[find_root(n)] & ~c_touch[find_root(n)];
                any |= odd_pu[n];
            end
            if (!any) break;
            foreach (e_a[e]) begin
                inc = int'(odd_pu[e_a[e]]) + ((e_b[e] >= 0) ? int'(odd_pu[e_b[e]]) : 0);
                cnt[e] = (cnt[e] + inc > e_w[e]) ? e_w[e] : cnt[e] + inc;
            end
            if (iter < 255) iter++;
        end
        for (int n = 0; n < N; n++) r[AW*n +: AW] = AW'(pu_addr(find_root(n)));
        r[EXP_W-1 -: 8] = 8'(iter);
        return r;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic check_roots(input string name, input logic [RW-1:0] expv);
        n_checks++;
        if (roots !== expv) begin
            n_fail++;
            for (int n = 0; n < N; n++) begin
                if (roots[AW*n +: AW] !== expv[AW*n +: AW]) begin
                    $display("FAIL %s: pu %0d root got %0d expected %0d", name, n,
                             roots[AW*n +: AW], expv[AW*n +: AW]);
                    break;
                end
            end
        end
    endtask

    task automatic start_round(input logic [N-1:0] m, input bit track);
        @(negedge clk);
        measurements = m;
        new_round_start = 1'b1;
        if (track) begin
            exp_q.push_back(ref_decode(m));
            pushes++;
        end
        @(negedge clk);
        new_round_start = 1'b0;
    endtask

    task automatic wait_result(input string name, output int cycles);
        cycles = 0;
        while (!result_valid && cycles < 2000) begin
            @(negedge clk);
            cycles++;
        end
        if (!result_valid) check({name, "_timeout"}, 0, 1);
    endtask

    // Monitor: every rising result_valid consumes one expected round.
    initial begin
        forever begin
            @(negedge clk);
            if (result_valid && !prev_valid) begin
                rises++;
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_roots("roots", mon_e[RW-1:0]);
                    check("iteration_counter", int'(iteration_counter), int'(mon_e[EXP_W-1 -: 8]));
`ifdef HELIOS_CYCLE_COUNTER_EN
                    check("cycle_counter_min",
                          int'(cycle_counter >= 32'(1 + 2*int'(mon_e[EXP_W-1 -: 8]))), 1);
`else
                    check("cycle_counter_off", int'(cycle_counter), 0);
`endif
                end
            end
            prev_valid = result_valid;
        end
    end

    initial begin
        int cyc, density;
        logic [N-1:0] m;
        for (int k = 0; k < NR; k++)
            for (int i = 0; i < DX; i++)
                for (int j = 0; j < DZ; j++) begin
                    int n;
                    n = pu_idx(i, j, k);
                    if (i < DX-1) begin e_a.push_back(n); e_b.push_back(pu_idx(i+1, j, k)); e_w.push_back(2); end
                    if (j < DZ-1) begin e_a.push_back(n); e_b.push_back(pu_idx(i, j+1, k)); e_w.push_back(2); end
                    if (k < NR-1) begin e_a.push_back(n); e_b.push_back(pu_idx(i, j, k+1)); e_w.push_back(2); end
                    if (j == 0)    begin e_a.push_back(n); e_b.push_back(-1); e_w.push_back(2); end
                    if (j == DZ-1) begin e_a.push_back(n); e_b.push_back(-1); e_w.push_back(2); end
                end

        reset = 1'b1;
        new_round_start = 1'b0;
        measurements = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_stage", int'(global_stage), 0);
        check("reset_valid", int'(result_valid), 0);
        check("reset_iter", int'(iteration_counter), 0);
        check("reset_cycles", int'(cycle_counter), 0);
        check_roots("reset_roots", own_roots());

        // All-zero round: LOADING then RESULT.
        start_round('0, 1);
        check("zero_loading_stage", int'(global_stage), 1);
        wait_result("zero", cyc);
        check("zero_latency_le2", int'(cyc <= 1), 1);
        repeat (3) @(negedge clk);
        check("zero_held_valid", int'(result_valid), 1);
        check("zero_held_stage", int'(global_stage), 4);

        // Adjacent pair joined along j after one growth.
        m = '0;
        m[pu_idx(1, 1, 0)] = 1'b1;
        m[pu_idx(1, 2, 0)] = 1'b1;
        start_round(m, 1);
        wait_result("pair", cyc);
        @(negedge clk);
        check("pair_root_a", int'(roots[AW*pu_idx(1, 1, 0) +: AW]), 9);
        check("pair_root_b", int'(roots[AW*pu_idx(1, 2, 0) +: AW]), 9);
        check("pair_iter", int'(iteration_counter), 1);

        // Single defect on the j=0 boundary.
        m = '0;
        m[pu_idx(2, 0, 0)] = 1'b1;
        start_round(m, 1);
        wait_result("single", cyc);
        @(negedge clk);
        check("single_root_200", int'(roots[AW*pu_idx(2, 0, 0) +: AW]), 8);
        check("single_root_100", int'(roots[AW*pu_idx(1, 0, 0) +: AW]), 8);
        check("single_root_300", int'(roots[AW*pu_idx(3, 0, 0) +: AW]), 8);
        check("single_root_210", int'(roots[AW*pu_idx(2, 1, 0) +: AW]), 8);
        check("single_root_201", int'(roots[AW*pu_idx(2, 0, 1) +: AW]), 8);
        check("single_root_other", int'(roots[AW*pu_idx(0, 0, 0) +: AW]), 0);
        check("single_iter", int'(iteration_counter), 2);

        // Restart straight out of RESULT.
        m = '0;
        m[pu_idx(0, 2, 1)] = 1'b1;
        m[pu_idx(3, 1, 3)] = 1'b1;
        start_round(m, 1);
        check("restart_valid_low", int'(result_valid), 0);
        check("restart_stage", int'(global_stage), 1);
        check("restart_iter", int'(iteration_counter), 0);
        check("restart_cycles", int'(cycle_counter), 0);
        wait_result("restart", cyc);

        // Abort mid-MERGE with an all-zero round.
        m = '0;
        m[pu_idx(2, 0, 0)] = 1'b1;
        start_round(m, 0);
        cyc = 0;
        while (global_stage != 3'd3 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_reached_merge", int'(global_stage), 3);
        start_round('0, 1);
        wait_result("abort", cyc);
        @(negedge clk);
        check("abort_iter", int'(iteration_counter), 0);
        check_roots("abort_roots_own", own_roots());

        // Random syndromes of varying density.
        for (int t = 0; t < 25; t++) begin
            density = $urandom_range(1, 12);
            for (int n = 0; n < N; n++) m[n] = ($urandom_range(0, 99) < density);
            start_round(m, 1);
            wait_result("random", cyc);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        check("all_results_seen", exp_q.size(), 0);
        check("result_rises", rises, pushes);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/helios_single_fpga.md
Name: helios_single_fpga

Overview:
Single-FPGA union-find decoder for a surface code with repeated measurement rounds. It holds a 3D lattice of processing units (PUs), one per stabilizer per round. For each syndrome round it grows odd clusters, merges touching clusters, and reports each PU's cluster root address. It sits between the syndrome-acquisition front end and the correction/peeling logic.

Parameters:
- CODE_DISTANCE_X, 5, lattice size in the i dimension.
- CODE_DISTANCE_Z, 4, lattice size in the j dimension.
- WEIGHT_X, 2, growth units to fully grow an i-direction edge.
- WEIGHT_Z, 2, growth units to fully grow a j-direction edge and each boundary edge.
- WEIGHT_M, 2, growth units to fully grow a k-direction (round-to-round) edge.
- Derived: MEASUREMENT_ROUNDS = max(CODE_DISTANCE_X, CODE_DISTANCE_Z).
- Derived: PU_COUNT = CODE_DISTANCE_X * CODE_DISTANCE_Z * MEASUREMENT_ROUNDS.
- Derived: PER_DIM_WIDTH = clog2(MEASUREMENT_ROUNDS); ADDRESS_WIDTH = 3 * PER_DIM_WIDTH.
- Derived: ITERATION_COUNTER_WIDTH = 8.

Ports:
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- new_round_start  in  1  one-cycle pulse; measurements are sampled on this cycle.
- measurements  in  PU_COUNT  defect bit per PU; PU (i,j,k) at index i*CODE_DISTANCE_Z + j + k*CODE_DISTANCE_Z*CODE_DISTANCE_X.
- roots  out  ADDRESS_WIDTH*PU_COUNT  root of PU n at slice [ADDRESS_WIDTH*n +: ADDRESS_WIDTH], encoded {k,i,j}, j in the LSBs.
- result_valid  out  1  high while roots are final.
- iteration_counter  out  8  number of GROW stages executed this round.
- cycle_counter  out  32  cycles spent decoding this round.
- global_stage  out  3  current stage encoding.

Behaviour:
- Stages (global_stage): 0 IDLE, 1 LOADING, 2 GROW, 3 MERGE, 4 RESULT.
- Reset: stage IDLE, result_valid=0, counters=0, defects=0, edges=0, every root = own address.
- new_round_start (any stage, reset low):
  - latch measurements; stage becomes LOADING next cycle.
  - clear all edge counters; roots = own address; iteration_counter=0; cycle_counter=0; result_valid=0.
  - a pulse mid-decode aborts the current round and restarts.
- Edges: one counter per neighbour pair in i (weight WEIGHT_X), j (WEIGHT_Z) and k (WEIGHT_M). PUs at j=0 and j=CODE_DISTANCE_Z-1 also have a boundary edge (weight WEIGHT_Z). An edge is full when its counter equals its weight; counters saturate at the weight.
- Cluster of PU p: all PUs q with root(q)==root(p).
  - parity = XOR of the cluster's defects.
  - touches_boundary = any cluster PU has a full boundary edge.
  - odd = parity & ~touches_boundary. Computed combinationally.
- LOADING (1 cycle) and each MERGE-stable cycle:
  - if no odd cluster, go to RESULT;
  - else go to GROW.
- GROW (1 cycle):
  - each edge counter += number of its endpoints in odd clusters (0..2);
  - each boundary edge += 1 if its PU is in an odd cluster;
  - iteration_counter += 1, saturating at 255; then go to MERGE.
- MERGE:
  - each cycle every PU sets root = numeric minimum of its own root and the roots of neighbours across full edges;
  - stays in MERGE while any root changed this cycle;
  - on the first cycle with no change, applies the odd-cluster check above.
  - Final root is therefore the minimum {k,i,j} address in the cluster.
- RESULT:
  - result_valid=1 and roots, iteration_counter, cycle_counter are held until the next new_round_start or reset;
  - result_valid rises exactly once per round.
- cycle_counter increments every cycle in LOADING, GROW and MERGE; it does not increment in IDLE or RESULT.
- A defect-free PU with no full edges keeps its own address as root.

Optional Feature:
- Macro HELIOS_CYCLE_COUNTER_EN.
- Defined: cycle_counter behaves as specified above.
- Undefined: the counter is not built and cycle_counter is tied to 0; all other behaviour is unchanged.

Test Plan:
All cases use the default parameters, so PER_DIM_WIDTH=3 and ADDRESS_WIDTH=9.
- Reset, then idle -> result_valid=0, global_stage=0, every root(i,j,k)={k,i,j}, both counters 0.
- All-zero measurements with a new_round_start pulse -> result_valid within 2 cycles, iteration_counter=0, roots equal own addresses.
- Defects at (i=1,j=1,k=0) and (i=1,j=2,k=0) -> one GROW fills their j edge (1+1=2). Expected: root of both PUs = 9; all other roots = own; iteration_counter=1.
- Single defect at (i=2,j=0,k=0) -> boundary and neighbour edges become full after 2 iterations. Expected: PUs (2,0,0), (1,0,0), (3,0,0), (2,1,0), (2,0,1) have root 8 (address of (1,0,0)); iteration_counter=2.
- new_round_start while in RESULT -> result_valid=0 the next cycle, global_stage=1, counters cleared, new round decoded correctly.
- new_round_start during MERGE of the single-defect case, with all-zero measurements -> round restarts; result has iteration_counter=0 and all roots equal own addresses.
